// File: rtl/apix_pkg.sv
// Shared widths, link state encoding and helpers for the APIX link controller.
package apix_pkg;

  localparam int unsigned PIXEL_W = 24;
  localparam int unsigned CRC_W   = 8;
  localparam int unsigned COUNT_W = 16;

  typedef enum logic [1:0] {
    LINK_DOWN  = 2'd0,
    LINK_TRAIN = 2'd1,
    LINK_UP    = 2'd2
  } link_state_t;

  // Received word as it arrives from the deserialiser.
  typedef struct packed {
    logic [PIXEL_W-1:0] pixel;
    logic [CRC_W-1:0]   crc;
  } rx_word_t;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/apix_pixel_fifo.sv
// Show-ahead synchronous pixel FIFO; a pop frees a slot for a same-cycle push.
module apix_pixel_fifo
  import apix_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = PIXEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_pop    = pop && !empty;
    do_push   = push && (!full || do_pop);
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + CW'(1);
    end else if (!do_push && do_pop) begin
      count_nxt = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_nxt;
      empty <= (count_nxt == CW'(0));
      full  <= (count_nxt == CW'(DEPTH));
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/apix_link_ctrl.sv
// APIX receiver link controller: down/train/up state machine, CRC error
// filtering, pixel buffering toward the display pipe and link statistics.
module apix_link_ctrl
  import apix_pkg::*;
#(
  parameter int unsigned LOCK_GOOD     = 4,
  parameter int unsigned ERR_LIMIT     = 3,
  parameter int unsigned ERR_WINDOW    = 64,
  parameter int unsigned TRAIN_TIMEOUT = 1024,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               link_en,
  input  logic               rx_word_valid,
  input  logic [PIXEL_W-1:0] rx_pixel,
  input  logic               rx_crc_err,
  output logic               rx_enable,
  output logic               rx_resync,
  output logic               pix_valid,
  output logic [PIXEL_W-1:0] pix_data,
  input  logic               pix_ready,
  output logic               link_up,
  output logic [1:0]         link_state,
  input  logic               err_clr,
  output logic               error_flag,
  output logic [COUNT_W-1:0] err_count,
  output logic [COUNT_W-1:0] drop_count
);

  localparam int unsigned GOOD_W = $clog2(LOCK_GOOD + 1);
  localparam int unsigned EWIN_W = $clog2(ERR_LIMIT + 1);
  localparam int unsigned WIN_W  = (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;
  localparam int unsigned TT_W   = (TRAIN_TIMEOUT > 1) ? $clog2(TRAIN_TIMEOUT) : 1;

  link_state_t       state;
  logic [GOOD_W-1:0] good_cnt;
  logic [TT_W-1:0]   train_timer;
  logic [EWIN_W-1:0] err_win;
  logic [EWIN_W-1:0] err_win_nxt;
  logic [WIN_W-1:0]  win_timer;

  logic word_good;
  logic word_bad;
  logic lock_hit;
  logic train_expired;
  logic win_wrap;
  logic err_trip;
  logic push_req;
  logic fifo_pop;
  logic fifo_flush;
  logic fifo_full;
  logic fifo_empty;
  logic drop_c;

  assign word_good     = rx_word_valid && !rx_crc_err;
  assign word_bad      = rx_word_valid && rx_crc_err;
  assign lock_hit      = word_good && (good_cnt == GOOD_W'(LOCK_GOOD - 1));
  assign train_expired = (train_timer == TT_W'(TRAIN_TIMEOUT - 1));
  assign win_wrap      = (win_timer == WIN_W'(ERR_WINDOW - 1));

  // Error window count after this cycle; a wrap restarts the window with the current word.
  always_comb begin
    err_win_nxt = err_win;
    if (win_wrap) begin
      err_win_nxt = word_bad ? EWIN_W'(1) : '0;
    end else if (word_bad) begin
      err_win_nxt = err_win + EWIN_W'(1);
    end
  end

  assign err_trip   = word_bad && (err_win_nxt == EWIN_W'(ERR_LIMIT));
  assign push_req   = link_en && (state == LINK_UP) && word_good;
  assign fifo_pop   = pix_ready && pix_valid;
  assign fifo_flush = !link_en || (state == LINK_DOWN);
  assign drop_c     = push_req && fifo_full && !fifo_pop;

  // Link state machine and its timers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LINK_DOWN;
      link_up     <= 1'b0;
      rx_enable   <= 1'b0;
      rx_resync   <= 1'b0;
      good_cnt    <= '0;
      train_timer <= '0;
      err_win     <= '0;
      win_timer   <= '0;
    end else begin
      rx_resync <= 1'b0;
      if (!link_en) begin
        state       <= LINK_DOWN;
        link_up     <= 1'b0;
        rx_enable   <= 1'b0;
        good_cnt    <= '0;
        train_timer <= '0;
        err_win     <= '0;
        win_timer   <= '0;
      end else begin
        unique case (state)
          LINK_DOWN: begin
            state       <= LINK_TRAIN;
            rx_enable   <= 1'b1;
            rx_resync   <= 1'b1;
            good_cnt    <= '0;
            train_timer <= '0;
          end
          LINK_TRAIN: begin
            if (lock_hit) begin
              state     <= LINK_UP;
              link_up   <= 1'b1;
              err_win   <= '0;
              win_timer <= '0;
            end else if (train_expired) begin
              rx_resync   <= 1'b1;
              good_cnt    <= '0;
              train_timer <= '0;
            end else begin
              train_timer <= train_timer + TT_W'(1);
              if (word_bad) begin
                good_cnt  <= '0;
                rx_resync <= 1'b1;
              end else if (word_good) begin
                good_cnt <= good_cnt + GOOD_W'(1);
              end
            end
          end
          LINK_UP: begin
            win_timer <= win_wrap ? '0 : win_timer + WIN_W'(1);
            err_win   <= err_win_nxt;
            if (err_trip) begin
              state       <= LINK_TRAIN;
              link_up     <= 1'b0;
              rx_resync   <= 1'b1;
              good_cnt    <= '0;
              train_timer <= '0;
            end
          end
          default: begin
            state     <= LINK_DOWN;
            link_up   <= 1'b0;
            rx_enable <= 1'b0;
          end
        endcase
      end
    end
  end

  // Statistics and the sticky error flag; a new error beats a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      error_flag <= 1'b0;
      err_count  <= '0;
      drop_count <= '0;
    end else begin
      if (word_bad && (state == LINK_UP)) begin
        error_flag <= 1'b1;
      end else if (err_clr) begin
        error_flag <= 1'b0;
      end
      if (word_bad && ((state == LINK_TRAIN) || (state == LINK_UP))) begin
        err_count <= sat_inc(err_count);
      end
      if (drop_c) begin
        drop_count <= sat_inc(drop_count);
      end
    end
  end

  assign link_state = state;
  assign pix_valid  = !fifo_empty;

  apix_pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIXEL_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (fifo_flush),
    .push  (push_req),
    .pop   (fifo_pop),
    .din   (rx_pixel),
    .dout  (pix_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_apix_link_ctrl.sv
// Scoreboard bench for apix_link_ctrl: directed link/FIFO scenarios with a
// decoupled pixel and resync monitor.
module tb_apix_link_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        link_en;
  logic        rx_word_valid;
  logic [23:0] rx_pixel;
  logic        rx_crc_err;
  logic        rx_enable;
  logic        rx_resync;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        pix_ready;
  logic        link_up;
  logic [1:0]  link_state;
  logic        err_clr;
  logic        error_flag;
  logic [15:0] err_count;
  logic [15:0] drop_count;

  int          n_vec = 0;
  int          n_miss = 0;
  int          resync_cnt = 0;
  int          base;
  logic        resync_prev = 1'b0;
  logic [23:0] exp_q [$];
  logic [23:0] exp_pix;

  always #5 clk = ~clk;

  apix_link_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .link_en       (link_en),
    .rx_word_valid (rx_word_valid),
    .rx_pixel      (rx_pixel),
    .rx_crc_err    (rx_crc_err),
    .rx_enable     (rx_enable),
    .rx_resync     (rx_resync),
    .pix_valid     (pix_valid),
    .pix_data      (pix_data),
    .pix_ready     (pix_ready),
    .link_up       (link_up),
    .link_state    (link_state),
    .err_clr       (err_clr),
    .error_flag    (error_flag),
    .err_count     (err_count),
    .drop_count    (drop_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] p, input logic bad);
    rx_word_valid = 1'b1;
    rx_pixel      = p;
    rx_crc_err    = bad;
    tick();
    rx_word_valid = 1'b0;
    rx_crc_err    = 1'b0;
  endtask

  task automatic goto_up();
    link_en = 1'b0;
    tick();
    link_en = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) send(24'hFFAA55 + 24'(i), 1'b0);
  endtask

  // Monitor: pops expected pixels on every accepted beat and tracks resync pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_resync) begin
        resync_cnt++;
        n_vec++;
        if (resync_prev) begin
          n_miss++;
          $display("FAIL resync_width: got 2+ cycle pulse expected 1 cycle");
        end
      end
      resync_prev = rx_resync;
      if (pix_valid && pix_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL pix_unexpected: got %06h expected none", pix_data);
        end else begin
          exp_pix = exp_q.pop_front();
          if (pix_data !== exp_pix) begin
            n_miss++;
            $display("FAIL pix_data: got %06h expected %06h", pix_data, exp_pix);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; link_en = 1'b0; rx_word_valid = 1'b0; rx_pixel = '0;
    rx_crc_err = 1'b0; pix_ready = 1'b0; err_clr = 1'b0;
    repeat (3) tick();
    check("rst_state", 32'(link_state), 32'd0);
    check("rst_rx_enable", 32'(rx_enable), 32'd0);
    check("rst_resync", 32'(rx_resync), 32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_pix_data", 32'(pix_data), 32'd0);
    check("rst_link_up", 32'(link_up), 32'd0);
    check("rst_error_flag", 32'(error_flag), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    rst = 1'b0;
    tick();

    // Bring-up: resync on DOWN->TRAIN, lock after four good words.
    link_en = 1'b1;
    tick();
    check("t1_state_train", 32'(link_state), 32'd1);
    check("t1_rx_enable", 32'(rx_enable), 32'd1);
    check("t1_resync", 32'(rx_resync), 32'd1);
    tick();
    check("t1_resync_low", 32'(rx_resync), 32'd0);
    for (int i = 0; i < 3; i++) send(24'hFFAA55 + 24'(i), 1'b0);
    check("t1_not_up_yet", 32'(link_up), 32'd0);
    send(24'hFFAA58, 1'b0);
    check("t1_link_up", 32'(link_up), 32'd1);
    check("t1_fifo_empty", 32'(pix_valid), 32'd0);
    check("t1_resync_cnt", 32'(resync_cnt), 32'd1);

    // Training interrupted by a bad word.
    link_en = 1'b0;
    tick();
    check("t2_down", 32'(link_state), 32'd0);
    link_en = 1'b1;
    tick();
    send(24'h000001, 1'b0);
    send(24'h000002, 1'b0);
    send(24'h000003, 1'b1);
    check("t2_resync_bad", 32'(rx_resync), 32'd1);
    for (int i = 0; i < 3; i++) send(24'h000010 + 24'(i), 1'b0);
    check("t2_not_up_6th", 32'(link_up), 32'd0);
    send(24'h000013, 1'b0);
    check("t2_up_7th", 32'(link_up), 32'd1);
    check("t2_err_count", 32'(err_count), 32'd1);
    check("t2_resync_cnt", 32'(resync_cnt), 32'd3);

    // Pixel flow with a ready consumer.
    pix_ready = 1'b1;
    exp_q.push_back(24'h123456);
    send(24'h123456, 1'b0);
    check("t3_valid_1", 32'(pix_valid), 32'd1);
    check("t3_data_1", 32'(pix_data), 32'h123456);
    exp_q.push_back(24'h789ABC);
    send(24'h789ABC, 1'b0);
    check("t3_valid_2", 32'(pix_valid), 32'd1);
    check("t3_data_2", 32'(pix_data), 32'h789ABC);
    tick();
    check("t3_valid_fall", 32'(pix_valid), 32'd0);

    // Fill with a stalled consumer, then push while full with a pop.
    pix_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) exp_q.push_back(24'hA00000 + 24'(i));
      send(24'hA00000 + 24'(i), 1'b0);
    end
    check("t4_drop_count", 32'(drop_count), 32'd2);
    check("t4_valid_full", 32'(pix_valid), 32'd1);
    pix_ready = 1'b1;
    exp_q.push_back(24'hA00006);
    send(24'hA00006, 1'b0);
    check("t4_no_drop_on_pop", 32'(drop_count), 32'd2);
    for (int i = 0; i < 20 && pix_valid; i++) tick();
    check("t4_drained", 32'(pix_valid), 32'd0);
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // Error window: three errors retrain, two-plus-two across a wrap do not.
    goto_up();
    base = resync_cnt;
    for (int i = 0; i < 3; i++) send(24'hBAD000 + 24'(i), 1'b1);
    check("t5_state_train", 32'(link_state), 32'd1);
    check("t5_resync", 32'(rx_resync), 32'd1);
    check("t5_error_flag", 32'(error_flag), 32'd1);
    tick();
    check("t5_one_resync", 32'(resync_cnt - base), 32'd1);
    check("t5_err_count", 32'(err_count), 32'd4);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t5_flag_cleared", 32'(error_flag), 32'd0);
    for (int i = 0; i < 4; i++) send(24'h00C000 + 24'(i), 1'b0);
    check("t5_relock", 32'(link_up), 32'd1);
    err_clr = 1'b1;
    send(24'hBAD010, 1'b1);
    err_clr = 1'b0;
    check("t5_set_beats_clr", 32'(error_flag), 32'd1);
    send(24'hBAD011, 1'b1);
    repeat (70) tick();
    send(24'hBAD012, 1'b1);
    send(24'hBAD013, 1'b1);
    check("t5_stays_up", 32'(link_state), 32'd2);
    check("t5_err_count_8", 32'(err_count), 32'd8);

    // Training timeout retry.
    link_en = 1'b0;
    tick();
    link_en = 1'b1;
    tick();
    tick();
    base = resync_cnt;
    repeat (1022) tick();
    check("t6_no_resync_early", 32'(rx_resync), 32'd0);
    tick();
    check("t6_timeout_resync", 32'(rx_resync), 32'd1);
    check("t6_still_train", 32'(link_state), 32'd1);
    tick();
    check("t6_one_resync", 32'(resync_cnt - base), 32'd1);

    // Link drop while the FIFO is draining.
    goto_up();
    pix_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(24'hD00000 + 24'(i));
      send(24'hD00000 + 24'(i), 1'b0);
    end
    pix_ready = 1'b1;
    tick();
    link_en = 1'b0;
    pix_ready = 1'b0;
    tick();
    check("t6_down", 32'(link_state), 32'd0);
    check("t6_flushed", 32'(pix_valid), 32'd0);
    check("t6_rx_disabled", 32'(rx_enable), 32'd0);
    check("t6_link_up_low", 32'(link_up), 32'd0);
    check("t6_queue_left", 32'(exp_q.size()), 32'd2);
    exp_q.delete();
    check("end_drop_count", 32'(drop_count), 32'd2);
    check("end_err_count", 32'(err_count), 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/apix_link_ctrl.md
# apix_link_ctrl

Link controller for the APIX serial pixel receiver. It enables and resynchronises the receiver and runs the link state machine (down / training / up). It filters CRC-errored words, buffers good pixels in a small FIFO toward the display pipeline, and keeps error and drop statistics. It sits between the receiver's per-word output strobe and the downstream pixel consumer.

## Interface
- LOCK_GOOD, 4: consecutive CRC-good words needed in TRAIN to declare link up.
- ERR_LIMIT, 3: CRC errors within one window in UP that force retraining.
- ERR_WINDOW, 64: error window length in clk cycles; fixed, free-running while in UP.
- TRAIN_TIMEOUT, 1024: cycles in TRAIN without lock before a resync retry.
- FIFO_DEPTH, 4: pixel buffer entries; power of two, ≥2.

Ports:
- clk  in  1  system clock; the block's only clock.
- rst  in  1  synchronous, active-high reset.
- link_en  in  1  level; link requested.
- rx_word_valid  in  1  one-cycle strobe per received 32-bit word (24 pixel + 8 CRC).
- rx_pixel  in  24  pixel word, qualified by rx_word_valid.
- rx_crc_err  in  1  CRC mismatch for the word, qualified by rx_word_valid.
- rx_enable  out  1  receiver enable.
- rx_resync  out  1  one-cycle pulse: receiver drops its bit alignment and CRC state.
- pix_valid  out  1  FIFO non-empty.
- pix_data  out  24  FIFO head; show-ahead.
- pix_ready  in  1  consumer accepts the head when pix_valid && pix_ready.
- link_up  out  1  state == UP.
- link_state  out  2  DOWN=0, TRAIN=1, UP=2.
- err_clr  in  1  clears error_flag.
- error_flag  out  1  sticky; set on any CRC error while in UP.
- err_count  out  16  CRC-errored words seen in TRAIN or UP; saturates at 16'hFFFF.
- drop_count  out  16  good words lost to a full FIFO; saturates at 16'hFFFF.

## Operation
- DOWN:
  - rx_enable=0; FIFO held empty; rx_word_valid ignored.
  - link_en=1 → TRAIN, with rx_resync pulsed in the transition cycle.
- TRAIN:
  - rx_enable=1.
  - A good word increments good_cnt.
  - A bad word clears good_cnt, pulses rx_resync and increments err_count.
  - good_cnt reaching LOCK_GOOD → UP.
  - train_timer reaching TRAIN_TIMEOUT-1 → pulse rx_resync, clear good_cnt and timer, stay in TRAIN.
  - TRAIN words are never pushed to the FIFO.
- UP:
  - Good word → FIFO push.
  - Bad word → discarded; err_count++, err_win++, error_flag set.
  - err_win is cleared when win_timer wraps (ERR_WINDOW-1 → 0). A wrap and an error in the same cycle give err_win=1.
  - err_win reaching ERR_LIMIT → TRAIN, with rx_resync pulsed. The FIFO keeps its contents and continues to drain.
- link_en=0 in any state → DOWN next cycle and the FIFO is flushed. This has priority over all other transitions.
- Entering TRAIN clears good_cnt and train_timer. Entering UP clears err_win and win_timer.
- FIFO:
  - Push and pop are allowed in the same cycle, including when full; the pop frees the slot and the word is not dropped.
  - Push when full with no pop → word dropped, drop_count++.
- error_flag: if set and err_clr occur in the same cycle, set wins.
- Counters saturate and never wrap. They are cleared only by rst.

## Timing
- Reset values (cycle after rst=1):
  - state=DOWN; rx_enable=0; rx_resync=0; pix_valid=0; pix_data=0.
  - link_up=0; link_state=0; error_flag=0; err_count=0; drop_count=0.
  - FIFO empty; all internal counters 0.
- All outputs are registered.
- rx_resync is high for exactly one cycle, in the cycle after the triggering event.
- Latency: good word strobed in UP at cycle N with FIFO empty → pix_valid=1 and pix_data valid at N+1.
- The LOCK_GOOD-th good word at cycle N → link_up=1 at N+1. A word in that same cycle is not pushed.
- The ERR_LIMIT-th error at cycle N → link_state=TRAIN at N+1.
- rst mid-operation: all state is discarded at once. No rx_resync pulse is generated by reset.

## Structure
- Package apix_pkg holds:
  - PIXEL_W=24 and CRC_W=8;
  - the link state encoding (LINK_DOWN, LINK_TRAIN, LINK_UP);
  - COUNT_W=16.
- Sub-module apix_pixel_fifo: sync FIFO, show-ahead, with push/pop/full/empty/flush ports.
- Top level holds the state machine, timers, statistics and drop logic.

## Test plan
- Reset, then link_en=1 and 4 good words (24'hFFAA55…) → rx_resync pulse on the DOWN→TRAIN transition; link_up=1 the cycle after the 4th word; FIFO empty.
- In TRAIN: 2 good words, 1 bad word, 4 good words → rx_resync pulse after the bad word; UP only after the 7th word; err_count=1.
- In UP: push 24'h123456, 24'h789ABC with pix_ready=1 → both appear in order, each one cycle after its strobe; pix_valid falls after the last pop.
- In UP with pix_ready=0: 6 good words → FIFO holds the first 4; drop_count=2. Then a push with pix_ready=1 while full → no drop.
- In UP: 3 bad words within 64 cycles → TRAIN with one rx_resync pulse; error_flag=1. Then 2 bad words, 64-cycle wrap, 2 more bad words → stays UP.
- In TRAIN with no words for 1024 cycles → rx_resync pulse; still TRAIN. Then link_en=0 mid-FIFO-drain → DOWN next cycle; pix_valid=0; rx_enable=0.
